mant_normalizer: RTL

MANT_NORMALIZER -- requirements
Module: mant_normalizer

---
 rtl/mant_normalizer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mant_normalizer.sv
// Post-add mantissa normalizer: carry right-shift, iterative left-shift, zero/overflow/denorm flags.
// Optional NORM_STICKY_EN adds out_sticky, the bit dropped by the carry right-shift.
module mant_normalizer #(
  parameter int N = 16,
  parameter int E = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mant,
  input  logic         in_carry,
  input  logic [E-1:0] in_exp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_mant,
  output logic [E-1:0] out_exp,
  output logic         out_zero,
  output logic         out_ovf,
`ifdef NORM_STICKY_EN
  output logic         out_sticky,
`endif
  output logic         out_denorm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [E-1:0] EXP_MAX = {E{1'b1}};

  state_t       state_q, state_d;
  logic [N-1:0] mant_q, mant_d;
  logic [E-1:0] exp_q, exp_d;
  logic         zero_q, zero_d;
  logic         ovf_q, ovf_d;
  logic         denorm_q, denorm_d;
`ifdef NORM_STICKY_EN
  logic         sticky_q, sticky_d;
`endif

  // One step of the left-shift loop, evaluated from the current registers.
  logic [N-1:0] mant_sh;
  logic [E-1:0] exp_sh;
  assign mant_sh = {mant_q[N-2:0], 1'b0};
  assign exp_sh  = exp_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      denorm_q <= 1'b0;
`ifdef NORM_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      denorm_q <= denorm_d;
`ifdef NORM_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    denorm_d = denorm_q;
`ifdef NORM_STICKY_EN
    sticky_d = sticky_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          denorm_d = 1'b0;
`ifdef NORM_STICKY_EN
          sticky_d = 1'b0;
`endif
          if (in_carry) begin
            state_d = DONE;
            if (in_exp == EXP_MAX) begin
              mant_d = '1;
              exp_d  = EXP_MAX;
              ovf_d  = 1'b1;
            end else begin
              mant_d = {1'b1, in_mant[N-1:1]};
              exp_d  = in_exp + 1'b1;
`ifdef NORM_STICKY_EN
              sticky_d = in_mant[0];
`endif
            end
          end else if (in_mant == '0) begin
            state_d = DONE;
            mant_d  = '0;
            exp_d   = '0;
            zero_d  = 1'b1;
          end else if (in_mant[N-1] || (in_exp == '0)) begin
            state_d  = DONE;
            mant_d   = in_mant;
            exp_d    = in_exp;
            denorm_d = ~in_mant[N-1];
          end else begin
            state_d = SHIFT;
            mant_d  = in_mant;
            exp_d   = in_exp;
          end
        end
      end
      SHIFT: begin
        mant_d = mant_sh;
        exp_d  = exp_sh;
        // Normalized wins over exhausted when both happen on the same step.
        if (mant_sh[N-1] || (exp_sh == '0)) begin
          state_d  = DONE;
          denorm_d = ~mant_sh[N-1];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_mant   = mant_q;
  assign out_exp    = exp_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_denorm = denorm_q;
`ifdef NORM_STICKY_EN
  assign out_sticky = sticky_q;
`endif

endmodule
